// File: rtl/gold_gen_mc_pkg.sv
// Shared types and helpers for the multi-channel Gold-code generator.
// Fibonacci LFSR step is kept here so every LFSR instance uses one definition.
package gold_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEG_DEFAULT = 5;
    localparam int L           = (1 << DEG_DEFAULT) - 1;
    localparam int IDX_W       = $clog2(L);
    localparam int MAX_DEG     = 16;

    // Vectors are zero-extended to MAX_DEG; deg selects where feedback enters.
    function automatic logic [MAX_DEG-1:0] lfsr_next(
        input logic [MAX_DEG-1:0] s,
        input logic [MAX_DEG-1:0] poly,
        input int                 deg
    );
        logic fb;
        fb = ^(s & poly);
        return (s >> 1) | (MAX_DEG'(fb) << (deg - 1));
    endfunction

endpackage

// File: rtl/gold_gen_mc_if.sv
// AXI-stream chip output bundle of the Gold-code generator.
interface gold_gen_mc_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] tdata;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/gold_gen_mc_lfsr_core.sv
// One Fibonacci LFSR with synchronous reset value, seed load and step enable.
module lfsr_core
    import gold_pkg::*;
#(
    parameter int             DEG     = 5,
    parameter logic [DEG-1:0] POLY    = '1,
    parameter logic [DEG-1:0] RST_VAL = '1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DEG-1:0] seed,
    input  logic           load,
    input  logic           step,
    output logic [DEG-1:0] state
);

    // NOTE: non-blocking assignment so all LFSRs update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= RST_VAL;
        else if (load)
            state <= seed;
        else if (step)
            state <= DEG'(lfsr_next(MAX_DEG'(state), MAX_DEG'(POLY), DEG));
    end

endmodule

// File: rtl/gold_gen_mc.sv
// Multi-channel Gold-code generator: shared LFSR A, per-channel LFSR B,
// paced by a divider and streamed out over AXI-stream with backpressure.
module gold_gen_mc
    import gold_pkg::*;
#(
    parameter int             DEG     = 5,
    parameter int             N_CH    = 4,
    parameter logic [DEG-1:0] POLY_A  = 5'b00101,
    parameter logic [DEG-1:0] POLY_B  = 5'b01111,
    parameter int             CLK_DIV = 1
) (
    input  logic                clkin,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_load,
    input  logic [DEG-1:0]      seed_a,
    input  logic [N_CH*DEG-1:0] seed_b,
    gold_gen_mc_if.master       m_axis,
    output logic                strobe_o,
    output logic                cfg_err
);

    localparam int                PERIOD     = (1 << DEG) - 1;
    localparam int                CIDX_W     = $clog2(PERIOD);
    localparam int                DIV_W      = 16;
    localparam logic [CIDX_W-1:0] LAST_IDX   = CIDX_W'(PERIOD - 1);
    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(CLK_DIV - 1);

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [CIDX_W-1:0] chip_idx;
    logic              seeds_ok;
    logic              load_ok;
    logic              valid;
    logic              hs;
    logic [DEG-1:0]    a_state;
    logic [DEG-1:0]    b_state [N_CH];
    logic              unused_hi;

    // NOTE: seeds_ok gets a default before the loop so no latch is inferred.
    always_comb begin
        seeds_ok = |seed_a;
        for (int k = 0; k < N_CH; k++)
            if (seed_b[k*DEG +: DEG] == '0)
                seeds_ok = 1'b0;
    end

    assign load_ok = (state == IDLE) && cfg_load && seeds_ok;
    assign valid   = (state == RUN) && (div_cnt == '0);
    assign hs      = valid && m_axis.tready;

    lfsr_core #(.DEG(DEG), .POLY(POLY_A), .RST_VAL('1)) u_lfsr_a (
        .clk(clkin), .rst(rst), .seed(seed_a), .load(load_ok), .step(hs), .state(a_state)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_lfsr_b
        lfsr_core #(.DEG(DEG), .POLY(POLY_B), .RST_VAL(DEG'(k + 1))) u_lfsr_b (
            .clk(clkin), .rst(rst), .seed(seed_b[k*DEG +: DEG]), .load(load_ok),
            .step(hs), .state(b_state[k])
        );
        assign m_axis.tdata[k] = a_state[0] ^ b_state[k][0];
    end

    // Only the chip bit of each register leaves the block.
    always_comb begin
        unused_hi = ^a_state[DEG-1:1];
        for (int k = 0; k < N_CH; k++)
            unused_hi = unused_hi ^ (^b_state[k][DEG-1:1]);
    end

    assign m_axis.tvalid = valid;
    assign m_axis.tlast  = valid && (chip_idx == LAST_IDX);

    always_ff @(posedge clkin) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            chip_idx <= '0;
            strobe_o <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            strobe_o <= hs && (chip_idx == '0);
            cfg_err  <= (state == IDLE) && cfg_load && !seeds_ok;
            case (state)
                IDLE: begin
                    if (load_ok)
                        chip_idx <= '0;
                    if (en) begin
                        state   <= RUN;
                        div_cnt <= '0;
                    end
                end
                RUN: begin
                    if (hs) begin
                        chip_idx <= (chip_idx == LAST_IDX) ? '0 : chip_idx + 1'b1;
                        div_cnt  <= DIV_RELOAD;
                        if (!en)
                            state <= IDLE;
                    end else if (!en && !valid) begin
                        // A pending beat must be accepted before leaving RUN.
                        state <= IDLE;
                    end else if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gold_gen_mc.sv
// Directed self-checking bench for gold_gen_mc (DEG=5, N_CH=4).
module tb_gold_gen_mc;

    logic clkin = 1'b0;
    always #5 clkin = ~clkin;

    logic        rst, en, en4, cfg_load;
    logic [4:0]  seed_a;
    logic [19:0] seed_b;
    logic        strobe, cfg_err, strobe4, cfg_err4;

    gold_gen_mc_if #(.N_CH(4)) axis ();
    gold_gen_mc_if #(.N_CH(4)) axis4 ();

    gold_gen_mc #(.DEG(5), .N_CH(4), .POLY_A(5'b00101), .POLY_B(5'b01111), .CLK_DIV(1)) dut (
        .clkin(clkin), .rst(rst), .en(en), .cfg_load(cfg_load), .seed_a(seed_a),
        .seed_b(seed_b), .m_axis(axis), .strobe_o(strobe), .cfg_err(cfg_err)
    );

    gold_gen_mc #(.DEG(5), .N_CH(4), .POLY_A(5'b00101), .POLY_B(5'b01111), .CLK_DIV(4)) dut4 (
        .clkin(clkin), .rst(rst), .en(en4), .cfg_load(cfg_load), .seed_a(seed_a),
        .seed_b(seed_b), .m_axis(axis4), .strobe_o(strobe4), .cfg_err(cfg_err4)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model of the generator state
    logic [4:0] ma;
    logic [4:0] mb [4];
    int         midx;

    function automatic logic [4:0] m_step(input logic [4:0] s, input logic [4:0] p);
        return {^(s & p), s[4:1]};
    endfunction

    function automatic logic [3:0] m_tdata();
        logic [3:0] t;
        for (int k = 0; k < 4; k++) t[k] = ma[0] ^ mb[k][0];
        return t;
    endfunction

    task automatic m_reset();
        ma = 5'h1F;
        for (int k = 0; k < 4; k++) mb[k] = 5'(k + 1);
        midx = 0;
    endtask

    task automatic m_load(input logic [4:0] sa, input logic [19:0] sb);
        ma = sa;
        for (int k = 0; k < 4; k++) mb[k] = sb[k*5 +: 5];
        midx = 0;
    endtask

    task automatic m_adv();
        ma = m_step(ma, 5'b00101);
        for (int k = 0; k < 4; k++) mb[k] = m_step(mb[k], 5'b01111);
        midx = (midx == 30) ? 0 : midx + 1;
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; en4 = 1'b0; cfg_load = 1'b0;
        seed_a = '0; seed_b = '0;
        axis.tready = 1'b0; axis4.tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", axis.tvalid); end
        n_chk++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", axis.tlast); end
        n_chk++; if (strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b want 0", strobe); end
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        n_chk++; if (axis.tdata !== 4'b1010) begin n_fail++; $display("FAIL reset_tdata: got %b want 1010", axis.tdata); end
        tick();
        n_chk++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL idle_hold_tvalid: got %b want 0", axis.tvalid); end
    endtask

    task automatic test_full_period();
        logic [3:0] first [31];
        int   beats = 0;
        logic exp_strobe = 1'b0;
        do_reset();
        en = 1'b1; axis.tready = 1'b1;
        tick();
        n_chk++; if (axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL first_valid_latency: got %b want 1", axis.tvalid); end
        n_chk++; if (axis.tdata !== 4'b1010) begin n_fail++; $display("FAIL first_beat_tdata: got %b want 1010", axis.tdata); end
        for (int c = 0; c < 80 && beats < 62; c++) begin
            n_chk++; if (strobe !== exp_strobe) begin n_fail++; $display("FAIL period_strobe beat %0d: got %b want %b", beats, strobe, exp_strobe); end
            exp_strobe = 1'b0;
            if (axis.tvalid && axis.tready) begin
                n_chk++; if (axis.tdata !== m_tdata()) begin n_fail++; $display("FAIL period_tdata beat %0d: got %b want %b", beats, axis.tdata, m_tdata()); end
                n_chk++; if (axis.tlast !== (midx == 30)) begin n_fail++; $display("FAIL period_tlast beat %0d: got %b want %b", beats, axis.tlast, midx == 30); end
                if (beats < 31) first[beats] = axis.tdata;
                else begin
                    n_chk++; if (axis.tdata !== first[beats-31]) begin n_fail++; $display("FAIL period_repeat beat %0d: got %b want %b", beats, axis.tdata, first[beats-31]); end
                end
                exp_strobe = (midx == 0);
                m_adv();
                beats++;
                if (beats == 62) en = 1'b0;
            end
            tick();
        end
        n_chk++; if (beats !== 62) begin n_fail++; $display("FAIL period_beat_count: got %0d want 62", beats); end
        n_chk++; if (strobe !== exp_strobe) begin n_fail++; $display("FAIL period_last_strobe: got %b want %b", strobe, exp_strobe); end
        n_chk++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL period_stop_tvalid: got %b want 0", axis.tvalid); end
    endtask

    task automatic test_backpressure();
        logic [63:0] pat = 64'hB3A5_0F6C_9D21_E47B;
        logic        prev_stall = 1'b0;
        logic [3:0]  prev_td = '0;
        int          beats = 0;
        do_reset();
        en = 1'b1;
        tick();
        for (int c = 0; c < 64; c++) begin
            axis.tready = pat[c];
            if (prev_stall) begin
                n_chk++; if (axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid_hold c=%0d: got %b want 1", c, axis.tvalid); end
                n_chk++; if (axis.tdata !== prev_td) begin n_fail++; $display("FAIL bp_tdata_hold c=%0d: got %b want %b", c, axis.tdata, prev_td); end
            end
            if (axis.tvalid) begin
                n_chk++; if (axis.tdata !== m_tdata()) begin n_fail++; $display("FAIL bp_tdata c=%0d: got %b want %b", c, axis.tdata, m_tdata()); end
            end
            prev_stall = axis.tvalid && !axis.tready;
            prev_td    = axis.tdata;
            if (axis.tvalid && axis.tready) begin
                m_adv();
                beats++;
            end
            tick();
        end
        n_chk++; if (beats !== $countones(pat)) begin n_fail++; $display("FAIL bp_beat_count: got %0d want %0d", beats, $countones(pat)); end
        en = 1'b0; axis.tready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_div4();
        int         last_hs = -1;
        int         nbeats = 0;
        logic [3:0] td;
        do_reset();
        en4 = 1'b1; axis4.tready = 1'b1;
        tick();
        n_chk++; if (axis4.tvalid !== 1'b1) begin n_fail++; $display("FAIL div4_latency: got %b want 1", axis4.tvalid); end
        n_chk++; if (axis4.tdata !== 4'b1010) begin n_fail++; $display("FAIL div4_first_tdata: got %b want 1010", axis4.tdata); end
        for (int c = 0; c < 40; c++) begin
            if (axis4.tvalid && axis4.tready) begin
                if (last_hs >= 0) begin
                    n_chk++; if (c - last_hs !== 4) begin n_fail++; $display("FAIL div4_spacing c=%0d: got %0d want 4", c, c - last_hs); end
                end
                last_hs = c;
                nbeats++;
            end
            tick();
        end
        n_chk++; if (nbeats !== 10) begin n_fail++; $display("FAIL div4_beat_count: got %0d want 10", nbeats); end
        n_chk++; if (axis4.tvalid !== 1'b1) begin n_fail++; $display("FAIL div4_beat_40: got %b want 1", axis4.tvalid); end
        axis4.tready = 1'b0; en4 = 1'b0; td = axis4.tdata;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++; if (axis4.tvalid !== 1'b1) begin n_fail++; $display("FAIL endrop_tvalid_hold c=%0d: got %b want 1", c, axis4.tvalid); end
            n_chk++; if (axis4.tdata !== td) begin n_fail++; $display("FAIL endrop_tdata_hold c=%0d: got %b want %b", c, axis4.tdata, td); end
        end
        axis4.tready = 1'b1;
        tick();
        n_chk++; if (axis4.tvalid !== 1'b0) begin n_fail++; $display("FAIL endrop_idle: got %b want 0", axis4.tvalid); end
        tick();
        n_chk++; if (axis4.tvalid !== 1'b0) begin n_fail++; $display("FAIL endrop_idle_stay: got %b want 0", axis4.tvalid); end
    endtask

    task automatic test_cfg_load();
        int beats = 0;
        do_reset();
        seed_a = 5'h1F;
        seed_b = {5'd4, 5'd0, 5'd2, 5'd1};
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL reject_cfg_err: got %b want 1", cfg_err); end
        tick();
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reject_cfg_err_pulse: got %b want 0", cfg_err); end
        en = 1'b1; axis.tready = 1'b1;
        tick();
        for (int c = 0; c < 20 && beats < 10; c++) begin
            n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL run_load_ignored c=%0d: got %b want 0", c, cfg_err); end
            cfg_load = (beats == 5);
            if (axis.tvalid) begin
                n_chk++; if (axis.tdata !== m_tdata()) begin n_fail++; $display("FAIL old_seed_tdata beat %0d: got %b want %b", beats, axis.tdata, m_tdata()); end
                m_adv();
                beats++;
                if (beats == 10) en = 1'b0;
            end
            tick();
        end
        cfg_load = 1'b0;
        n_chk++; if (beats !== 10) begin n_fail++; $display("FAIL old_seed_beats: got %0d want 10", beats); end
        tick();
        seed_b = {5'd4, 5'd3, 5'd2, 5'b10101};
        cfg_load = 1'b1; en = 1'b1;
        m_load(seed_a, seed_b);
        tick();
        cfg_load = 1'b0;
        n_chk++; if (axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL load_en_tvalid: got %b want 1", axis.tvalid); end
        n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL valid_load_cfg_err: got %b want 0", cfg_err); end
        n_chk++; if (axis.tdata !== 4'b1010) begin n_fail++; $display("FAIL new_seed_first: got %b want 1010", axis.tdata); end
        beats = 0;
        for (int c = 0; c < 40 && beats < 31; c++) begin
            if (axis.tvalid) begin
                n_chk++; if (axis.tdata !== m_tdata()) begin n_fail++; $display("FAIL new_seed_tdata beat %0d: got %b want %b", beats, axis.tdata, m_tdata()); end
                n_chk++; if (axis.tlast !== (midx == 30)) begin n_fail++; $display("FAIL new_seed_tlast beat %0d: got %b want %b", beats, axis.tlast, midx == 30); end
                m_adv();
                beats++;
                if (beats == 31) en = 1'b0;
            end
            tick();
        end
        n_chk++; if (beats !== 31) begin n_fail++; $display("FAIL new_seed_beats: got %0d want 31", beats); end
    endtask

    task automatic test_xcorr();
        logic [3:0] code [31];
        int beats = 0;
        int v;
        int bad_v;
        logic ok;
        do_reset();
        en = 1'b1; axis.tready = 1'b1;
        tick();
        for (int c = 0; c < 40 && beats < 31; c++) begin
            if (axis.tvalid) begin
                code[beats] = axis.tdata;
                beats++;
                if (beats == 31) en = 1'b0;
            end
            tick();
        end
        n_chk++; if (beats !== 31) begin n_fail++; $display("FAIL xcorr_beats: got %0d want 31", beats); end
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                ok = 1'b1; bad_v = 0;
                for (int s = 0; s < 31; s++) begin
                    v = 0;
                    for (int n = 0; n < 31; n++)
                        v += (code[n][i] ^ code[(n + s) % 31][j]) ? -1 : 1;
                    if (v != -9 && v != -1 && v != 7) begin ok = 1'b0; bad_v = v; end
                end
                n_chk++; if (!ok) begin n_fail++; $display("FAIL xcorr ch%0d/ch%0d: got %0d want one of -9,-1,7", i, j, bad_v); end
            end
        end
    endtask

    task automatic test_rst_mid();
        int   beats = 0;
        logic exp_strobe = 1'b0;
        do_reset();
        en = 1'b1; axis.tready = 1'b1;
        tick();
        for (int c = 0; c < 30 && beats < 17; c++) begin
            if (axis.tvalid) begin
                n_chk++; if (axis.tdata !== m_tdata()) begin n_fail++; $display("FAIL pre_rst_tdata beat %0d: got %b want %b", beats, axis.tdata, m_tdata()); end
                m_adv();
                beats++;
            end
            tick();
        end
        n_chk++; if (axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL beat18_valid: got %b want 1", axis.tvalid); end
        rst = 1'b1;
        tick();
        n_chk++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid: got %b want 0", axis.tvalid); end
        n_chk++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tlast: got %b want 0", axis.tlast); end
        n_chk++; if (strobe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_strobe: got %b want 0", strobe); end
        n_chk++; if (axis.tdata !== 4'b1010) begin n_fail++; $display("FAIL rst_mid_tdata: got %b want 1010", axis.tdata); end
        rst = 1'b0;
        m_reset();
        tick();
        beats = 0;
        for (int c = 0; c < 3; c++) begin
            n_chk++; if (strobe !== exp_strobe) begin n_fail++; $display("FAIL restart_strobe c=%0d: got %b want %b", c, strobe, exp_strobe); end
            n_chk++; if (axis.tvalid !== 1'b1) begin n_fail++; $display("FAIL restart_tvalid c=%0d: got %b want 1", c, axis.tvalid); end
            n_chk++; if (axis.tdata !== m_tdata()) begin n_fail++; $display("FAIL restart_tdata c=%0d: got %b want %b", c, axis.tdata, m_tdata()); end
            exp_strobe = (midx == 0);
            m_adv();
            tick();
        end
        en = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_period();
        test_backpressure();
        test_div4();
        test_cfg_load();
        test_xcorr();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
